fc_sequencer: RTL and testbench

- Time-multiplexed fully connected layer: y = W x + b computed one multiply-accumulate per cycle.
- Weights, inputs and biases are fetched from external synchronous memories, not presented as full parallel arrays.
- Used when a fully parallel dot-product array is too large. Sits between the layer buffers and the next activation stage.
- Results leave as a valid/ready stream, one output neuron at a time.

---
 rtl/fc_seq_pkg.sv | 22 ++
 rtl/fc_mac_unit.sv | 45 ++++
 rtl/fc_sequencer.sv | 153 +++++++++++++++
 tb/tb_fc_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fc_seq_pkg.sv
// Shared types and sizing helpers for the time-multiplexed fully connected layer.
package fc_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MAC   = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } fc_seq_state_t;

  // Accumulator width that cannot overflow for in_len full-width products.
  function automatic int unsigned acc_width(input int unsigned width, input int unsigned in_len);
    return 2 * width + $clog2(in_len) + 1;
  endfunction

  // Address width, never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fc_mac_unit.sv
// Signed multiply with a wide accumulator; next_acc exposes acc + current product.
module fc_mac_unit
  import fc_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ACC_W = acc_width(32, 16)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [ACC_W-1:0] next_acc
);

  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;

  // Full-precision product and next accumulator value.
  always_comb begin
    prod     = a * b;
    next_acc = acc_q + ACC_W'(prod);
    acc_d    = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = next_acc;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/fc_sequencer.sv
// Fully connected layer y = W x + b, one MAC per cycle, results as a valid/ready stream.
module fc_sequencer
  import fc_seq_pkg::*;
#(
  parameter  int unsigned WIDTH      = 32,
  parameter  int unsigned FRAC_BITS  = 16,
  parameter  int unsigned IN_LENGTH  = 16,
  parameter  int unsigned OUT_LENGTH = 16,
  localparam int unsigned WA_W       = addr_w(OUT_LENGTH * IN_LENGTH),
  localparam int unsigned XA_W       = addr_w(IN_LENGTH),
  localparam int unsigned BA_W       = addr_w(OUT_LENGTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             mem_rd_en,
  output logic [WA_W-1:0]  w_addr,
  output logic [XA_W-1:0]  x_addr,
  output logic [BA_W-1:0]  b_addr,
  input  logic [WIDTH-1:0] w_rdata,
  input  logic [WIDTH-1:0] x_rdata,
  input  logic [WIDTH-1:0] b_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [BA_W-1:0]  out_index
);

  localparam int unsigned ACC_W = acc_width(WIDTH, IN_LENGTH);

  fc_seq_state_t           state_q, state_d;
  logic [BA_W-1:0]         o_q, o_d;
  logic [XA_W-1:0]         j_q, j_d;
  logic [WA_W-1:0]         w_addr_q, w_addr_d;
  logic                    acc_en_q;
  logic                    acc_clear;
  logic                    out_valid_q, out_valid_d;
  logic [WIDTH-1:0]        out_data_q, out_data_d;
  logic [BA_W-1:0]         out_index_q, out_index_d;
  logic signed [ACC_W-1:0] acc, next_acc, final_acc;

  fc_mac_unit #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .clear    (acc_clear),
    .en       (acc_en_q),
    .a        (w_rdata),
    .b        (x_rdata),
    .acc      (acc),
    .next_acc (next_acc)
  );

  // Row sum including the product that lands in the DRAIN cycle.
  assign final_acc = acc_en_q ? next_acc : acc;

  // Sequencer next-state, counters and output register.
  // The bias read issued during MAC is already valid in DRAIN, so the result is
  // registered on the DRAIN->EMIT edge and out_valid rises on EMIT entry.
  always_comb begin
    state_d     = state_q;
    o_d         = o_q;
    j_d         = j_q;
    w_addr_d    = w_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    acc_clear   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = MAC;
          o_d       = '0;
          j_d       = '0;
          w_addr_d  = '0;
          acc_clear = 1'b1;
        end
      end
      MAC: begin
        if (j_q == XA_W'(IN_LENGTH - 1)) begin
          state_d = DRAIN;
        end else begin
          j_d      = j_q + 1'b1;
          w_addr_d = w_addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d     = EMIT;
        out_valid_d = 1'b1;
        out_index_d = o_q;
        out_data_d  = WIDTH'((final_acc >>> FRAC_BITS) + ACC_W'(signed'(b_rdata)));
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (o_q == BA_W'(OUT_LENGTH - 1)) begin
            state_d = DONE;
          end else begin
            state_d   = MAC;
            o_d       = o_q + 1'b1;
            j_d       = '0;
            w_addr_d  = w_addr_q + 1'b1;
            acc_clear = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      o_q         <= '0;
      j_q         <= '0;
      w_addr_q    <= '0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      o_q         <= o_d;
      j_q         <= j_d;
      w_addr_q    <= w_addr_d;
      acc_en_q    <= (state_q == MAC);
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
    end
  end

  assign busy      = (state_q == MAC) || (state_q == DRAIN) || (state_q == EMIT);
  assign done      = (state_q == DONE);
  assign mem_rd_en = (state_q == MAC) || (state_q == DRAIN);
  assign w_addr    = w_addr_q;
  assign x_addr    = j_q;
  assign b_addr    = o_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed scoreboard bench for fc_sequencer across three layer shapes.
module tb_fc_sequencer;
  import fc_seq_pkg::*;

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  // DUT A: IN=2, OUT=2
  logic        start_a, busy_a, done_a, rd_a, ov_a, rdy_a;
  logic [1:0]  wa_a;
  logic        xa_a, ba_a, oi_a;
  logic [31:0] wr_a, xr_a, br_a, od_a;
  // DUT B: IN=1, OUT=2
  logic        start_b, busy_b, done_b, rd_b, ov_b, rdy_b;
  logic        wa_b, xa_b, ba_b, oi_b;
  logic [31:0] wr_b, xr_b, br_b, od_b;
  // DUT C: IN=1, OUT=1
  logic        start_c, busy_c, done_c, rd_c, ov_c, rdy_c;
  logic        wa_c, xa_c, ba_c, oi_c;
  logic [31:0] wr_c, xr_c, br_c, od_c;

  logic [31:0] wm_a [4] = '{32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0001_0000};
  logic [31:0] xm_a [2] = '{32'h0001_8000, 32'hFFFE_0000};
  logic [31:0] bm_a [2] = '{32'h0000_4000, 32'h0000_0000};
  logic [31:0] wm_b [2] = '{32'h0000_0001, 32'hFFFF_FFFF};
  logic [31:0] xm_b [2] = '{32'h0000_8000, 32'h0000_0000};
  logic [31:0] bm_b [2] = '{32'h0000_0000, 32'h0000_0000};
  logic [31:0] wm_c [2] = '{32'h0080_0000, 32'h0000_0000};
  logic [31:0] xm_c [2] = '{32'h0100_0000, 32'h0000_0000};
  logic [31:0] bm_c [2] = '{32'h0000_0000, 32'h0000_0000};

  fc_sequencer #(.WIDTH(32), .FRAC_BITS(16), .IN_LENGTH(2), .OUT_LENGTH(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .mem_rd_en(rd_a), .w_addr(wa_a), .x_addr(xa_a), .b_addr(ba_a),
    .w_rdata(wr_a), .x_rdata(xr_a), .b_rdata(br_a),
    .out_valid(ov_a), .out_ready(rdy_a), .out_data(od_a), .out_index(oi_a)
  );

  fc_sequencer #(.WIDTH(32), .FRAC_BITS(16), .IN_LENGTH(1), .OUT_LENGTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .mem_rd_en(rd_b), .w_addr(wa_b), .x_addr(xa_b), .b_addr(ba_b),
    .w_rdata(wr_b), .x_rdata(xr_b), .b_rdata(br_b),
    .out_valid(ov_b), .out_ready(rdy_b), .out_data(od_b), .out_index(oi_b)
  );

  fc_sequencer #(.WIDTH(32), .FRAC_BITS(16), .IN_LENGTH(1), .OUT_LENGTH(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .busy(busy_c), .done(done_c),
    .mem_rd_en(rd_c), .w_addr(wa_c), .x_addr(xa_c), .b_addr(ba_c),
    .w_rdata(wr_c), .x_rdata(xr_c), .b_rdata(br_c),
    .out_valid(ov_c), .out_ready(rdy_c), .out_data(od_c), .out_index(oi_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory models, one cycle latency.
  always @(posedge clk) begin
    if (rd_a) begin
      wr_a <= wm_a[wa_a];
      xr_a <= xm_a[xa_a];
      br_a <= bm_a[ba_a];
    end
    if (rd_b) begin
      wr_b <= wm_b[wa_b];
      xr_b <= xm_b[xa_b];
      br_b <= bm_b[ba_b];
    end
    if (rd_c) begin
      wr_c <= wm_c[wa_c];
      xr_c <= xm_c[xa_c];
      br_c <= bm_c[ba_c];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic extra_output(input string tag, input logic [31:0] obs);
    checks++;
    errors++;
    $error("FAIL %s observed unexpected output %0h expected none", tag, obs);
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_rd"}, rd_a, 0);
    check({tag, "_valid"}, ov_a, 0);
    check({tag, "_waddr"}, wa_a, 0);
    check({tag, "_xaddr"}, xa_a, 0);
    check({tag, "_baddr"}, ba_a, 0);
    check({tag, "_data"}, od_a, 0);
    check({tag, "_index"}, oi_a, 0);
    check({tag, "_state"}, 64'(dut_a.state_q), 64'(IDLE));
    check({tag, "_acc"}, 64'(dut_a.u_mac.acc), 0);
  endtask

  // Runs one layer on DUT A starting at the current negedge (cycle 0).
  task automatic run_a(input string tag, input int stall_from, input int stall_len,
                       input int exp_done, input bit mac_pulse, input bit done_pulse,
                       input int rst_at);
    exp_t e;
    int   last_k;
    bit   rdy;
    bit   busy_exp;
    bit   done_exp;
    qa.push_back('{0, 32'h0001_C000});
    qa.push_back('{1, 32'hFFFE_0000});
    start_a = 1'b1;
    last_k  = (rst_at != 0) ? rst_at + 4 : exp_done + 1;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge clk);
      rdy   = !(k >= stall_from && k < stall_from + stall_len);
      rdy_a = rdy;
      if (k == 1) start_a = 1'b0;
      if (mac_pulse && k == 2) start_a = 1'b1;
      if (mac_pulse && k == 3) start_a = 1'b0;
      if (done_pulse && k == exp_done) start_a = 1'b1;
      if (rst_at != 0 && k == rst_at) rst = 1'b1;
      if (rst_at != 0 && k == rst_at + 1) begin
        rst = 1'b0;
        check_a_reset({tag, "_midrst"});
        qa.delete();
      end
      if (ov_a && rdy_a) begin
        if (qa.size() == 0) begin
          extra_output({tag, "_extra"}, od_a);
        end else begin
          e = qa.pop_front();
          check({tag, "_idx"}, oi_a, e.idx);
          check({tag, "_data"}, od_a, e.data);
        end
      end
      if (!rdy) begin
        check({tag, "_stall_valid"}, ov_a, 1);
        check({tag, "_stall_rd"}, rd_a, 0);
        if (qa.size() != 0) begin
          check({tag, "_stall_idx"}, oi_a, qa[0].idx);
          check({tag, "_stall_data"}, od_a, qa[0].data);
        end
      end
      busy_exp = (rst_at != 0 && k > rst_at) ? 1'b0 : (k < exp_done);
      done_exp = (rst_at == 0 || k <= rst_at) && (k == exp_done);
      check($sformatf("%s_busy_c%0d", tag, k), busy_a, busy_exp);
      check($sformatf("%s_done_c%0d", tag, k), done_a, done_exp);
    end
    check({tag, "_q_empty"}, qa.size(), 0);
  endtask

  // Runs the two IN=1 layers side by side with out_ready held high.
  task automatic run_bc();
    exp_t e;
    qb.push_back('{0, 32'h0000_0000});
    qb.push_back('{1, 32'hFFFF_FFFF});
    qc.push_back('{0, 32'h8000_0000});
    start_b = 1'b1;
    start_c = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_b = 1'b0;
        start_c = 1'b0;
      end
      if (ov_b && rdy_b) begin
        if (qb.size() == 0) begin
          extra_output("B_extra", od_b);
        end else begin
          e = qb.pop_front();
          check("B_idx", oi_b, e.idx);
          check("B_data", od_b, e.data);
        end
      end
      if (ov_c && rdy_c) begin
        if (qc.size() == 0) begin
          extra_output("C_extra", od_c);
        end else begin
          e = qc.pop_front();
          check("C_idx", oi_c, e.idx);
          check("C_data", od_c, e.data);
        end
      end
      check($sformatf("B_busy_c%0d", k), busy_b, (k <= 6));
      check($sformatf("B_done_c%0d", k), done_b, (k == 7));
      check($sformatf("C_busy_c%0d", k), busy_c, (k <= 3));
      check($sformatf("C_done_c%0d", k), done_c, (k == 4));
    end
    check("B_q_empty", qb.size(), 0);
    check("C_q_empty", qc.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
    rdy_a   = 1'b1;
    rdy_b   = 1'b1;
    rdy_c   = 1'b1;
    repeat (2) @(negedge clk);
    check_a_reset("reset");
    check("reset_B_busy", busy_b, 0);
    check("reset_C_valid", ov_c, 0);
    rst = 1'b0;

    run_a("A_basic", 0, 0, 9, 1'b0, 1'b0, 0);
    run_a("A_stall", 4, 5, 14, 1'b0, 1'b0, 0);
    run_a("A_rst", 0, 0, 9, 1'b0, 1'b0, 5);
    run_a("A_ignore", 0, 0, 9, 1'b1, 1'b1, 0);
    run_a("A_chain", 0, 0, 9, 1'b0, 1'b0, 0);
    run_bc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
